// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and types for the memory-mapped divider
// Register byte offsets, STATUS bit positions and the divider FSM state encoding.
// Optional feature macro: DIV_SIGNED_EN (adds the SIGN register at 0x1C).
package div_pkg;

    localparam logic [4:0] OFF_A      = 5'h04;
    localparam logic [4:0] OFF_B      = 5'h08;
    localparam logic [4:0] OFF_INIT   = 5'h0C;
    localparam logic [4:0] OFF_QUOT   = 5'h10;
    localparam logic [4:0] OFF_REM    = 5'h14;
    localparam logic [4:0] OFF_STATUS = 5'h18;
    localparam logic [4:0] OFF_SIGN   = 5'h1C;

    localparam int ST_DONE_BIT = 0;
    localparam int ST_BUSY_BIT = 1;
    localparam int ST_DZ_BIT   = 2;
    localparam int ST_SIGN_BIT = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } div_state_e;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - restoring shift-subtract divider, one quotient bit per clock
// Ports: clk, resetn (async, active low), start (pulse, ignored while busy),
//        a/b operands, signed_mode (only with DIV_SIGNED_EN),
//        busy/done/dz flags, quot/rem results (held until the next completion).
// Optional feature macro: DIV_SIGNED_EN.
module div_core
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // working remainder
    logic [WIDTH-1:0] shreg_q, shreg_d;  // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] div_q, div_d;      // divisor magnitude latched at start
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
`ifdef DIV_SIGNED_EN
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
`endif

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] acc_nx, shreg_nx;

    // State register (all flops)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            shreg_q <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && (b != '0)) state_d = S_RUN;
            S_RUN:  if (cnt_q == '0)        state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and flag updates
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = done_q;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
        a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
`else
        a_mag   = a;
        b_mag   = b;
`endif

        // One restoring step: the shifted remainder is one bit wider so the
        // borrow of the trial subtraction decides the quotient bit.
        rem_sh   = {acc_q, shreg_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, div_q};
        acc_nx   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        shreg_nx = {shreg_q[WIDTH-2:0], ~trial[WIDTH]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        quot_d = '1;
                        rem_d  = a;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        acc_d   = '0;
                        shreg_d = a_mag;
                        div_d   = b_mag;
                        cnt_d   = CNT_LAST;
                        done_d  = 1'b0;
                        dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
                        negq_d  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negr_d  = signed_mode & a[WIDTH-1];
`endif
                    end
                end
            end
            S_RUN: begin
                acc_d   = acc_nx;
                shreg_d = shreg_nx;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
`ifdef DIV_SIGNED_EN
                    quot_d = negq_q ? (~shreg_nx + 1'b1) : shreg_nx;
                    rem_d  = negr_q ? (~acc_nx + 1'b1) : acc_nx;
`else
                    quot_d = shreg_nx;
                    rem_d  = acc_nx;
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == S_RUN);
        done = done_q;
        dz   = dz_q;
        quot = quot_q;
        rem  = rem_q;
    end

endmodule

// File: rtl/peripheral_div.sv
// rtl/peripheral_div.sv - memory-mapped sequential divider peripheral
// Ports: clk, resetn (async, active low), d_in write data, cs chip select,
//        addr byte offset, rd/wr strobes, d_out registered read data (32 bits).
// Map: 0x04 A, 0x08 B, 0x0C INIT, 0x10 QUOT, 0x14 REM, 0x18 STATUS,
//      0x1C SIGN (only with DIV_SIGNED_EN; STATUS bit3 mirrors it).
// Optional feature macro: DIV_SIGNED_EN.
module peripheral_div
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_in,
    input  logic             cs,
    input  logic [4:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [31:0]      d_out
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [31:0]      dout_q, dout_d;
`ifdef DIV_SIGNED_EN
    logic             sign_q, sign_d;
`endif

    logic             wr_en, rd_en, start;
    logic             busy, done, dz;
    logic [WIDTH-1:0] quot, rem;
    logic [31:0]      rdata;

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .a           (a_q),
        .b           (b_q),
`ifdef DIV_SIGNED_EN
        .signed_mode (sign_q),
`endif
        .busy        (busy),
        .done        (done),
        .dz          (dz),
        .quot        (quot),
        .rem         (rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q    <= '0;
            b_q    <= '0;
            dout_q <= '0;
`ifdef DIV_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            dout_q <= dout_d;
`ifdef DIV_SIGNED_EN
            sign_q <= sign_d;
`endif
        end
    end

    // Write decode; the core itself ignores a start while it is running.
    always_comb begin
        wr_en = cs & wr;
        rd_en = cs & rd;
        start = wr_en && (addr == OFF_INIT) && d_in[0];
        a_d   = (wr_en && (addr == OFF_A) && !busy) ? d_in : a_q;
        b_d   = (wr_en && (addr == OFF_B) && !busy) ? d_in : b_q;
`ifdef DIV_SIGNED_EN
        sign_d = (wr_en && (addr == OFF_SIGN)) ? d_in[0] : sign_q;
`endif
    end

    // Read mux samples pre-edge values, so a same-cycle write is not visible.
    always_comb begin
        rdata = '0;
        case (addr)
            OFF_QUOT: rdata[WIDTH-1:0] = quot;
            OFF_REM:  rdata[WIDTH-1:0] = rem;
            OFF_STATUS: begin
                rdata[ST_DONE_BIT] = done;
                rdata[ST_BUSY_BIT] = busy;
                rdata[ST_DZ_BIT]   = dz;
`ifdef DIV_SIGNED_EN
                rdata[ST_SIGN_BIT] = sign_q;
`endif
            end
            default: rdata = '0;
        endcase
        dout_d = rd_en ? rdata : dout_q;
        d_out  = dout_q;
    end

endmodule

// File: tb/tb_peripheral_div.sv
// tb/tb_peripheral_div.sv - self-checking bench for peripheral_div
// Optional feature macro: DIV_SIGNED_EN (enables the signed-mode steps).
module tb_peripheral_div;

`ifdef DIV_SIGNED_EN
    localparam bit HAS_SIGN = 1'b1;
`else
    localparam bit HAS_SIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] d_in;
    logic        cs, rd, wr;
    logic [4:0]  addr;
    logic [31:0] d_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit sgn_mode = 1'b0;

    always #5 clk = ~clk;

    peripheral_div #(.WIDTH(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (d_in),
        .cs     (cs),
        .addr   (addr),
        .rd     (rd),
        .wr     (wr),
        .d_out  (d_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reads STATUS every cycle until done, bounded.
    task automatic poll(output int k, output int nbusy, output logic [31:0] st);
        k = 0; nbusy = 0; st = '0;
        do begin
            bus_read(5'h18, st);
            k++;
            if (st[1]) nbusy++;
        end while (!st[0] && k < 60);
    endtask

    // Reference: plain integer division following the peripheral's rules.
    task automatic ref_div(input logic [15:0] a, input logic [15:0] b, input bit sgn,
                           output logic [15:0] q, output logic [15:0] r);
        int sa, sb;
        if (b == 0) begin
            q = 16'hFFFF; r = a;
        end else if (sgn) begin
            sa = int'($signed(a)); sb = int'($signed(b));
            q = 16'(sa / sb); r = 16'(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er;
        logic [31:0] st, v;
        int k, nb;
        ref_div(a, b, sgn_mode, eq, er);
        bus_write(5'h04, a);
        bus_write(5'h08, b);
        bus_write(5'h0C, 16'h1);
        poll(k, nb, st);
        check({tag, " latency"}, k, (b == 0) ? 1 : 17);
        check({tag, " busy_cycles"}, nb, (b == 0) ? 0 : 16);
        check({tag, " status"}, st, ((b == 0) ? 32'h5 : 32'h1) | (32'(sgn_mode) << 3));
        bus_read(5'h10, v);
        check({tag, " quot"}, v, {16'h0, eq});
        bus_read(5'h14, v);
        check({tag, " rem"}, v, {16'h0, er});
    endtask

    initial begin
        logic [31:0] v, held;
        logic [15:0] ra, rb;
        int k, nb;

        resetn = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        #2;
        check("reset d_out", d_out, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        bus_read(5'h18, v); check("reset status", v, 32'h0);
        bus_read(5'h10, v); check("reset quot", v, 32'h0);
        bus_read(5'h14, v); check("reset rem", v, 32'h0);

        run_div("100/7", 16'd100, 16'd7);

        // d_out holds when no read strobe
        held = d_out;
        idle(2);
        check("d_out hold", d_out, held);

        run_div("5/0", 16'd5, 16'd0);
        run_div("0/9", 16'd0, 16'd9);
        run_div("6/9", 16'd6, 16'd9);
        run_div("ffff/1", 16'hFFFF, 16'd1);

        // INIT with bit0 clear is a no-op; done stays sticky
        bus_write(5'h0C, 16'h2);
        bus_read(5'h18, v); check("init0 status", v, 32'h1);

        // Unmapped offsets read zero
        bus_read(5'h00, v); check("read 0x00", v, 32'h0);
        bus_read(5'h0C, v); check("read INIT", v, 32'h0);
        bus_read(5'h1C, v); check("read 0x1C", v, 32'h0);

        // A write and INIT re-start during a run are ignored
        bus_write(5'h04, 16'hFFFF);
        bus_write(5'h08, 16'h1);
        bus_write(5'h0C, 16'h1);
        idle(2);
        bus_write(5'h04, 16'h3);
        bus_write(5'h0C, 16'h1);
        poll(k, nb, v);
        check("busy-ignore latency", k, 13);
        bus_read(5'h10, v); check("busy-ignore quot", v, 32'hFFFF);
        bus_read(5'h14, v); check("busy-ignore rem", v, 32'h0);

        // Same-cycle rd+wr on INIT: read returns the (zero) pre-write value, start happens
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 5'h0C; d_in = 16'h1;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        check("rdwr d_out", d_out, 32'h0);
        bus_read(5'h18, v); check("rdwr status busy", v, 32'h2);
        poll(k, nb, v);

        // Asynchronous reset mid-run
        bus_write(5'h04, 16'd1000);
        bus_write(5'h08, 16'd3);
        bus_write(5'h0C, 16'h1);
        idle(7);
        #2 resetn = 1'b0;
        #1 check("midrun reset d_out", d_out, 32'h0);
        @(posedge clk); #1 resetn = 1'b1;
        bus_read(5'h18, v); check("midrun status", v, 32'h0);
        bus_read(5'h10, v); check("midrun quot", v, 32'h0);
        bus_read(5'h14, v); check("midrun rem", v, 32'h0);
        run_div("1000/3", 16'd1000, 16'd3);

        // Randomized unsigned divisions
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            run_div($sformatf("rnd%0d", i), ra, rb);
        end

        // Signed mode (STATUS bit3 only exists with the feature)
        bus_write(5'h1C, 16'h1);
        sgn_mode = HAS_SIGN;
        bus_read(5'h18, v); check("sign status", v, 32'h1 | (32'(sgn_mode) << 3));
        run_div("-100/7", 16'hFF9C, 16'd7);
        run_div("100/-7", 16'd100, 16'hFFF9);
        run_div("-5/0", 16'hFFFB, 16'd0);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 65535));
            run_div($sformatf("srnd%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
